// File: rtl/oc8051_ia_log_pkg.sv
// Shared constants and record layout for the illegal-access log.
// PROC0_IA is the source code the page table also uses for processor 0.
package oc8051_ia_log_pkg;

  localparam logic [15:0] OC8051_IA_LOG_BASE = 16'hffc8;

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_ADDR_HI = 3'd1;
  localparam logic [2:0] OFF_ADDR_LO = 3'd2;
  localparam logic [2:0] OFF_PC_HI   = 3'd3;
  localparam logic [2:0] OFF_PC_LO   = 3'd4;
  localparam logic [2:0] OFF_SRC     = 3'd5;
  localparam logic [2:0] OFF_CTRL    = 3'd6;
  localparam logic [2:0] OFF_DROP    = 3'd7;

  localparam logic [2:0] PROC0_IA = 3'd5;

  localparam int ADDR_W = 16;
  localparam int PC_W   = 16;
  localparam int SRC_W  = 3;
  localparam int REC_W  = 40;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PC_W-1:0]   pc;
    logic [SRC_W-1:0]  src;
    logic              rwn;
    logic [3:0]        pad;
  } ia_rec_t;

  function automatic logic [2:0] ia_src(input logic [2:0] port, input logic proc);
    if (port != 3'd0) return port;
    return proc ? 3'd0 : PROC0_IA;
  endfunction

endpackage

// File: rtl/oc8051_ia_fifo.sv
// Synchronous FIFO; a push together with a pop is accepted even when full.
module oc8051_ia_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 40,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/oc8051_ia_log.sv
// Logs every XRAM access denied by the page table into a FIFO and exposes
// the oldest record through an 8-byte privileged register window.
module oc8051_ia_log
  import oc8051_ia_log_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = OC8051_IA_LOG_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xram_stb,
  input  logic        xram_wr,
  input  logic [15:0] xram_addr,
  input  logic [7:0]  xram_data_in,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  selected_port,
  input  logic        selected_proc,
  input  logic [15:0] dpc_ot,
  input  logic        priv_lvl,
  input  logic        log_stb,
  output logic        log_ack,
  output logic        log_addr_range,
  output logic [7:0]  log_data_out,
  output logic        ia_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             viol, push_req, armed;
  logic             ctrl_wr, pop_req, clr_req;
  logic             push_ok, pop_ok, drop;
  logic             full, empty;
  logic [CW-1:0]    count, count_next;
  logic [4:0]       count5;
  logic [16:0]      rel;
  logic [2:0]       offset, src;
  logic             overflow, irq_en, irq_en_next;
  logic [7:0]       drop_cnt;
  ia_rec_t          rec_in, head;
  logic [REC_W-1:0] head_bits;

  assign viol     = xram_stb && ((xram_wr && !wr_en) || (!xram_wr && !rd_en));
  assign push_req = viol && armed;
  assign src      = ia_src(selected_port, selected_proc);

  // PC is only meaningful when the processor itself owns the bus.
  assign rec_in.addr = xram_addr;
  assign rec_in.pc   = (selected_port == 3'd0) ? dpc_ot : 16'h0000;
  assign rec_in.src  = src;
  assign rec_in.rwn  = xram_wr;
  assign rec_in.pad  = 4'b0;

  assign rel            = {1'b0, xram_addr} - {1'b0, BASE_ADDR};
  assign log_addr_range = (rel < 17'd8);
  assign offset         = rel[2:0];
  assign log_ack        = log_stb && log_addr_range;

  assign ctrl_wr = log_ack && xram_wr && priv_lvl && (offset == OFF_CTRL);
  assign pop_req = ctrl_wr && xram_data_in[0];
  assign clr_req = ctrl_wr && xram_data_in[1];

  assign pop_ok      = pop_req && !empty;
  assign push_ok     = push_req && (!full || pop_ok);
  assign drop        = push_req && !push_ok;
  assign count_next  = count + CW'(push_ok) - CW'(pop_ok);
  assign irq_en_next = ctrl_wr ? xram_data_in[2] : irq_en;

  oc8051_ia_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (rec_in),
    .dout  (head_bits),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head   = ia_rec_t'(head_bits);
  assign count5 = 5'(count);

  // armed makes one stalled strobe produce exactly one record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed    <= 1'b1;
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
      irq_en   <= 1'b0;
      ia_irq   <= 1'b0;
    end else begin
      if (push_req)      armed <= 1'b0;
      else if (!xram_stb) armed <= 1'b1;
      if (clr_req)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (clr_req)                       drop_cnt <= drop ? 8'h01 : 8'h00;
      else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'h01;
      irq_en <= irq_en_next;
      ia_irq <= irq_en_next && (count_next != '0);
    end
  end

  always_comb begin
    log_data_out = 8'h00;
    if (priv_lvl && log_addr_range) begin
      case (offset)
        OFF_STATUS:  log_data_out = {overflow, 2'b00, count5};
        OFF_ADDR_HI: log_data_out = empty ? 8'h00 : head.addr[15:8];
        OFF_ADDR_LO: log_data_out = empty ? 8'h00 : head.addr[7:0];
        OFF_PC_HI:   log_data_out = empty ? 8'h00 : head.pc[15:8];
        OFF_PC_LO:   log_data_out = empty ? 8'h00 : head.pc[7:0];
        OFF_SRC:     log_data_out = empty ? 8'h00 : {3'b000, head.rwn, 1'b0, head.src};
        OFF_CTRL:    log_data_out = {5'b00000, irq_en, 2'b00};
        default:     log_data_out = drop_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_oc8051_ia_log.sv
// Directed bench for the illegal-access log: record capture, window reads,
// overflow/drop handling, concurrent push/pop, privilege gating and reset.
module tb_oc8051_ia_log;

  localparam logic [15:0] BASE = 16'hffc8;

  logic        clk = 1'b0;
  logic        rst;
  logic        xram_stb, xram_wr, wr_en, rd_en, selected_proc, priv_lvl, log_stb;
  logic [15:0] xram_addr, dpc_ot;
  logic [7:0]  xram_data_in;
  logic [2:0]  selected_port;
  logic        log_ack, log_addr_range, ia_irq;
  logic [7:0]  log_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oc8051_ia_log #(.DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .xram_stb       (xram_stb),
    .xram_wr        (xram_wr),
    .xram_addr      (xram_addr),
    .xram_data_in   (xram_data_in),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .selected_port  (selected_port),
    .selected_proc  (selected_proc),
    .dpc_ot         (dpc_ot),
    .priv_lvl       (priv_lvl),
    .log_stb        (log_stb),
    .log_ack        (log_ack),
    .log_addr_range (log_addr_range),
    .log_data_out   (log_data_out),
    .ia_irq         (ia_irq)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic reg_read(input logic [2:0] off, output logic [7:0] d);
    @(negedge clk);
    xram_stb  = 1'b0;
    xram_wr   = 1'b0;
    log_stb   = 1'b1;
    xram_addr = BASE + 16'(off);
    #1 d = log_data_out;
    log_stb = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] data);
    @(negedge clk);
    xram_stb     = 1'b0;
    log_stb      = 1'b1;
    xram_wr      = 1'b1;
    xram_addr    = BASE + 16'd6;
    xram_data_in = data;
    @(negedge clk);
    log_stb = 1'b0;
    xram_wr = 1'b0;
  endtask

  task automatic do_viol(input logic [15:0] addr, input logic wr, input logic [2:0] port,
                         input logic proc, input logic [15:0] pc, input int cycles);
    @(negedge clk);
    xram_stb      = 1'b1;
    xram_wr       = wr;
    xram_addr     = addr;
    wr_en         = !wr;
    rd_en         = wr;
    selected_port = port;
    selected_proc = proc;
    dpc_ot        = pc;
    repeat (cycles) @(negedge clk);
    xram_stb = 1'b0;
    xram_wr  = 1'b0;
    wr_en    = 1'b1;
    rd_en    = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    reg_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", d); end
    checks++; if (ia_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", ia_irq); end
    @(negedge clk);
    xram_addr = 16'hffcf; log_stb = 1'b0;
    #1 checks++; if (log_ack !== 1'b0) begin failures++; $display("FAIL ack_no_stb got=%b exp=0", log_ack); end
    checks++; if (log_addr_range !== 1'b1) begin failures++; $display("FAIL range_top got=%b exp=1", log_addr_range); end
    log_stb = 1'b1;
    #1 checks++; if (log_ack !== 1'b1) begin failures++; $display("FAIL ack_stb got=%b exp=1", log_ack); end
    xram_addr = 16'hffd0;
    #1 checks++; if (log_ack !== 1'b0 || log_addr_range !== 1'b0) begin failures++; $display("FAIL range_above got=%b/%b exp=0/0", log_ack, log_addr_range); end
    xram_addr = 16'hffc7;
    #1 checks++; if (log_addr_range !== 1'b0) begin failures++; $display("FAIL range_below got=%b exp=0", log_addr_range); end
    log_stb = 1'b0;
  endtask

  task automatic test_single_record();
    logic [7:0] d;
    logic [2:0] offs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] exp  [6] = '{8'h01, 8'h12, 8'h34, 8'h04, 8'h56, 8'h15};
    ctrl_write(8'h04);
    @(negedge clk);
    xram_stb = 1'b1; xram_wr = 1'b1; xram_addr = 16'h1234; wr_en = 1'b0; rd_en = 1'b1;
    selected_port = 3'd0; selected_proc = 1'b0; dpc_ot = 16'h0456;
    checks++; if (ia_irq !== 1'b0) begin failures++; $display("FAIL irq_before got=%b exp=0", ia_irq); end
    @(negedge clk);
    checks++; if (ia_irq !== 1'b1) begin failures++; $display("FAIL irq_n_plus_1 got=%b exp=1", ia_irq); end
    repeat (2) @(negedge clk);
    xram_stb = 1'b0; xram_wr = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reg_read(offs[i], d);
      checks++; if (d !== exp[i]) begin failures++; $display("FAIL rec1_off%0d got=%h exp=%h", offs[i], d, exp[i]); end
    end
  endtask

  task automatic test_pop();
    logic [7:0] d;
    logic [2:0] offs [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] exp  [5] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h03};
    do_viol(16'h8000, 1'b0, 3'd3, 1'b1, 16'habcd, 1);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL pop_pre_status got=%h exp=02", d); end
    ctrl_write(8'h05);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL pop_status got=%h exp=01", d); end
    checks++; if (ia_irq !== 1'b1) begin failures++; $display("FAIL pop_irq_held got=%b exp=1", ia_irq); end
    for (int i = 0; i < 5; i++) begin
      reg_read(offs[i], d);
      checks++; if (d !== exp[i]) begin failures++; $display("FAIL rec2_off%0d got=%h exp=%h", offs[i], d, exp[i]); end
    end
    ctrl_write(8'h05);
    checks++; if (ia_irq !== 1'b0) begin failures++; $display("FAIL irq_empty got=%b exp=0", ia_irq); end
    reg_read(3'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL empty_head got=%h exp=00", d); end
    ctrl_write(8'h01);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL pop_empty got=%h exp=00", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i < 9; i++) do_viol(16'h0100 + 16'(i), 1'b1, 3'd1, 1'b1, 16'h0000, 1);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h88) begin failures++; $display("FAIL ovf_status got=%h exp=88", d); end
    reg_read(3'd7, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL drop_cnt got=%h exp=01", d); end
    ctrl_write(8'h06);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h08) begin failures++; $display("FAIL clr_status got=%h exp=08", d); end
    reg_read(3'd7, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL clr_drop got=%h exp=00", d); end
    reg_read(3'd6, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL ctrl_read got=%h exp=04", d); end
    checks++; if (ia_irq !== 1'b1) begin failures++; $display("FAIL irq_full got=%b exp=1", ia_irq); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [2:0] offs [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] exp  [5] = '{8'hff, 8'hce, 8'h00, 8'h00, 8'h12};
    @(negedge clk);
    xram_stb = 1'b1; xram_wr = 1'b1; wr_en = 1'b0; rd_en = 1'b1;
    xram_addr = BASE + 16'd6; xram_data_in = 8'h05; log_stb = 1'b1;
    selected_port = 3'd2; selected_proc = 1'b1; dpc_ot = 16'h9999;
    @(negedge clk);
    xram_stb = 1'b0; xram_wr = 1'b0; wr_en = 1'b1; log_stb = 1'b0;
    reg_read(3'd0, d);
    checks++; if (d !== 8'h08) begin failures++; $display("FAIL b2b_status got=%h exp=08", d); end
    reg_read(3'd2, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL b2b_head got=%h exp=01", d); end
    repeat (7) ctrl_write(8'h05);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL b2b_count got=%h exp=01", d); end
    for (int i = 0; i < 5; i++) begin
      reg_read(offs[i], d);
      checks++; if (d !== exp[i]) begin failures++; $display("FAIL tail_off%0d got=%h exp=%h", offs[i], d, exp[i]); end
    end
    ctrl_write(8'h05);
    reg_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL b2b_drain got=%h exp=00", d); end
  endtask

  task automatic test_priv_and_reset();
    logic [7:0] d;
    do_viol(16'h2222, 1'b1, 3'd0, 1'b0, 16'h0777, 1);
    priv_lvl = 1'b0;
    reg_read(3'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL unpriv_read got=%h exp=00", d); end
    ctrl_write(8'h01);
    priv_lvl = 1'b1;
    reg_read(3'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL unpriv_write got=%h exp=01", d); end
    checks++; if (ia_irq !== 1'b1) begin failures++; $display("FAIL irq_pending got=%b exp=1", ia_irq); end
    @(negedge clk);
    xram_stb = 1'b1; xram_wr = 1'b1; wr_en = 1'b0; xram_addr = 16'h3333;
    #2 rst = 1'b0;
    #1 checks++; if (ia_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", ia_irq); end
    xram_stb = 1'b0; xram_wr = 1'b0; wr_en = 1'b1;
    reg_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", d); end
    reg_read(3'd6, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_ctrl got=%h exp=00", d); end
    @(negedge clk);
    rst = 1'b1;
    reg_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL post_rst_status got=%h exp=00", d); end
  endtask

  initial begin
    rst = 1'b0; xram_stb = 1'b0; xram_wr = 1'b0; xram_addr = 16'h0000;
    xram_data_in = 8'h00; wr_en = 1'b1; rd_en = 1'b1; selected_port = 3'd0;
    selected_proc = 1'b0; dpc_ot = 16'h0000; priv_lvl = 1'b1; log_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_single_record();
    test_pop();
    test_overflow();
    test_back_to_back();
    test_priv_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
